// File: rtl/ram_sequencer.sv
// Burst initiator for the 16-bit RAM: turns write/read burst commands into per-word
// RAM opcodes, with a small first-word-fall-through buffer for read returns.
module ram_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] ram_opcode,
    output logic [DATA_WIDTH-1:0] ram_operand,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(16'h4100);
    localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(16'h4200);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [DATA_WIDTH-1:0] r_opcode;
    logic [DATA_WIDTH-1:0] r_operand;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [OW-1:0]         r_occ;

    logic [ADDR_WIDTH:0]   w_cnt_inc;
    logic                  w_cnt_last;
    logic [OW:0]           w_pend;
    logic                  w_room;
    logic                  w_wr_hs;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_drained;
    logic                  w_rd_en;

    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_cnt_last = (w_cnt_inc == r_len);
    // Buffer slots already promised: stored words plus reads still in the RAM pipe.
    assign w_pend     = {1'b0, r_occ} + {{OW{1'b0}}, r_inflight[0]} + {{OW{1'b0}}, r_inflight[1]};
    assign w_room     = (w_pend < (OW+1)'(BUF_DEPTH));
    assign w_wr_hs    = wr_ready && wr_valid;
    assign w_issue    = (r_state == S_READ) && (r_cnt < r_len) && w_room;
    assign w_pop      = rd_valid && rd_ready;
    assign w_capture  = r_inflight[1];
    assign w_drained  = (r_inflight == 2'b00) &&
                        ((r_occ == '0) || ((r_occ == OW'(1)) && w_pop));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0)  w_next = S_DONE;
                    else if (cmd_write) w_next = S_WRITE;
                    else                w_next = S_READ;
                end
            end
            S_WRITE: if (w_wr_hs && w_cnt_last) w_next = S_DONE;
            S_READ:  if ((w_issue && w_cnt_last) || (r_cnt == r_len)) w_next = S_DRAIN;
            S_DRAIN: if (w_drained) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        wr_ready  = (r_state == S_WRITE);
        done      = (r_state == S_DONE);
        w_rd_en   = (r_state == S_READ) || (r_state == S_DRAIN);
        rd_valid  = w_rd_en && (r_occ != '0);
        rd_data   = rd_valid ? r_buf[r_rptr] : '0;
        dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_wdata    <= '0;
            r_inflight <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
        end else begin
            // RAM outputs are single-cycle strobes; idle by default.
            r_opcode  <= '0;
            r_operand <= '0;
            r_wdata   <= '0;
            if (cmd_valid && cmd_ready) begin
                r_addr <= cmd_base;
                r_len  <= cmd_len;
                r_cnt  <= '0;
            end
            if (w_wr_hs) begin
                r_opcode  <= OP_WR;
                r_operand <= {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, r_addr};
                r_wdata   <= wr_data;
                r_addr    <= r_addr + 1'b1;
                r_cnt     <= w_cnt_inc;
            end
            if (w_issue) begin
                r_opcode  <= OP_RD;
                r_operand <= {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, r_addr};
                r_addr    <= r_addr + 1'b1;
                r_cnt     <= w_cnt_inc;
            end
            r_inflight <= {r_inflight[0], w_issue};
            if (w_capture) begin
                r_buf[r_wptr] <= ram_read_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_capture, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign ram_opcode     = r_opcode;
    assign ram_operand    = r_operand;
    assign ram_write_data = r_wdata;

endmodule

// File: tb/tb_ram_sequencer.sv
// Directed bench for ram_sequencer with a behavioural RAM, an issue log and a read-data scoreboard.
module tb_ram_sequencer;
  localparam int BUF_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_base = '0;
  logic [8:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic [15:0] ram_opcode;
  logic [15:0] ram_operand;
  logic [15:0] ram_write_data;
  logic [15:0] ram_read_data = '0;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  ram_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_opcode(ram_opcode), .ram_operand(ram_operand),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // behavioural RAM: samples the opcode at the edge, read data valid the cycle after
  logic [15:0] ram_mem [256];
  initial for (int i = 0; i < 256; i++) ram_mem[i] = 16'h5A00 | 16'(i);
  always @(posedge clk) begin
    if (ram_opcode == 16'h4100) ram_mem[ram_operand[7:0]] <= ram_write_data;
    if (ram_opcode == 16'h4200) ram_read_data <= ram_mem[ram_operand[7:0]];
  end

  // scoreboard
  logic [47:0] exp_q[$];
  logic [47:0] iss_q[$];
  int          iss_cyc[$];
  logic [15:0] exp_rd_q[$];
  logic [15:0] rd_q[$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (ram_opcode != 16'h0000) begin
      iss_q.push_back({ram_opcode, ram_operand, ram_write_data});
      iss_cyc.push_back(cyc);
    end
    if (rd_valid && rd_ready) begin
      rd_q.push_back(rd_data);
      last_pop_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dut.r_occ > 3'(BUF_DEPTH)) chk("buf_overflow", 64'(dut.r_occ), 64'(BUF_DEPTH));
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    exp_q.delete(); iss_q.delete(); iss_cyc.delete(); exp_rd_q.delete(); rd_q.delete();
  endtask

  task automatic wait_done(input string tag, input int target);
    int g = 0;
    while (done_cnt < target && g < 300) begin tick(); g++; end
    chk(tag, 64'(done_cnt), 64'(target));
  endtask

  task automatic compare_issues(input string tag);
    chk({tag, "_n"}, 64'(iss_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < iss_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(iss_q[i]), 64'(exp_q[i]));
  endtask

  task automatic compare_reads(input string tag);
    chk({tag, "_n"}, 64'(rd_q.size()), 64'(exp_rd_q.size()));
    for (int i = 0; i < exp_rd_q.size() && i < rd_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(rd_q[i]), 64'(exp_rd_q[i]));
  endtask

  task automatic start_cmd(input logic wr, input logic [7:0] base, input logic [8:0] len);
    cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] base, input logic [15:0] words[4], input int len,
                          input bit gaps);
    int sent = 0;
    int g = 0;
    bit gap = 1'b0;
    bit hs;
    start_cmd(1'b1, base, 9'(len));
    while (sent < len && g < 100) begin
      if (gaps && gap) wr_valid = 1'b0;
      else begin wr_valid = 1'b1; wr_data = words[sent]; end
      gap = ~gap;
      hs = wr_valid && wr_ready;
      tick();
      g++;
      if (hs) sent++;
    end
    wr_valid = 1'b0;
    chk("wr_sent", 64'(sent), 64'(len));
  endtask

  logic [15:0] wtab[4];
  int base_done;
  int k;

  initial begin
    // reset state
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_opcode", 64'(ram_opcode), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // write burst 0x10 x3, wr_valid held high
    clear_logs();
    wtab = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000};
    base_done = done_cnt;
    do_write(8'h10, wtab, 3, 1'b0);
    wait_done("wr_done", base_done + 1);
    exp_q = '{{16'h4100, 16'h0010, 16'hAAAA}, {16'h4100, 16'h0011, 16'hBBBB},
              {16'h4100, 16'h0012, 16'hCCCC}};
    compare_issues("wr_iss");
    if (iss_cyc.size() == 3) begin
      chk("wr_consec0", 64'(iss_cyc[1] - iss_cyc[0]), 64'd1);
      chk("wr_consec1", 64'(iss_cyc[2] - iss_cyc[1]), 64'd1);
    end
    chk("ram_10", 64'(ram_mem[8'h10]), 64'hAAAA);
    chk("ram_12", 64'(ram_mem[8'h12]), 64'hCCCC);
    tick();
    chk("wr_single_done", 64'(done_cnt), 64'(base_done + 1));

    // read burst 0x10 x3, rd_ready high
    clear_logs();
    rd_ready = 1'b1;
    base_done = done_cnt;
    start_cmd(1'b0, 8'h10, 9'd3);
    k = 0;
    while (!rd_valid && k < 20) begin tick(); k++; end
    chk("rd_latency", 64'(k), 64'd3);
    wait_done("rd_done", base_done + 1);
    exp_rd_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    compare_reads("rd_data");
    chk("rd_done_after_pop", 64'(done_cyc - last_pop_cyc), 64'd1);
    exp_q = '{{16'h4200, 16'h0010, 16'h0000}, {16'h4200, 16'h0011, 16'h0000},
              {16'h4200, 16'h0012, 16'h0000}};
    compare_issues("rd_iss");

    // read with backpressure across the address wrap
    clear_logs();
    rd_ready = 1'b0;
    base_done = done_cnt;
    start_cmd(1'b0, 8'hFE, 9'd8);
    repeat (20) tick();
    chk("bp_stall_issues", 64'(iss_q.size()), 64'd4);
    chk("bp_rd_valid", 64'(rd_valid), 64'd1);
    chk("bp_no_done", 64'(done_cnt), 64'(base_done));
    rd_ready = 1'b1;
    wait_done("bp_done", base_done + 1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      a = 8'hFE + 8'(i);
      exp_q.push_back({16'h4200, 8'h00, a, 16'h0000});
      exp_rd_q.push_back(16'h5A00 | {8'h00, a});
    end
    compare_issues("bp_iss");
    compare_reads("bp_data");

    // zero-length command
    clear_logs();
    base_done = done_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 8'h55; cmd_len = 9'd0;
    tick();
    cmd_valid = 1'b0;
    chk("zl_done", 64'(done), 64'd1);
    chk("zl_opcode", 64'(ram_opcode), 64'd0);
    tick();
    chk("zl_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("zl_done_low", 64'(done), 64'd0);
    tick();
    chk("zl_no_issue", 64'(iss_q.size()), 64'd0);
    chk("zl_done_cnt", 64'(done_cnt), 64'(base_done + 1));

    // write with gaps
    clear_logs();
    wtab = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    base_done = done_cnt;
    do_write(8'h30, wtab, 4, 1'b1);
    wait_done("gap_done", base_done + 1);
    exp_q = '{{16'h4100, 16'h0030, 16'h1111}, {16'h4100, 16'h0031, 16'h2222},
              {16'h4100, 16'h0032, 16'h3333}, {16'h4100, 16'h0033, 16'h4444}};
    compare_issues("gap_iss");
    for (int i = 0; i + 1 < iss_cyc.size(); i++)
      chk($sformatf("gap_spacing_%0d", i), 64'(iss_cyc[i+1] - iss_cyc[i]), 64'd2);

    // reset in the middle of a read burst
    clear_logs();
    rd_ready = 1'b1;
    start_cmd(1'b0, 8'h40, 9'd5);
    k = 0;
    while (rd_q.size() < 2 && k < 50) begin tick(); k++; end
    chk("mid_two_words", 64'(rd_q.size()), 64'd2);
    reset = 1'b0;
    #1;
    chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_ram_outs", 64'({ram_opcode, ram_operand, ram_write_data}), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("post_rst_rd_valid", 64'(rd_valid), 64'd0);
    clear_logs();
    base_done = done_cnt;
    start_cmd(1'b0, 8'h20, 9'd1);
    wait_done("post_rst_done", base_done + 1);
    repeat (3) tick();
    exp_q = '{{16'h4200, 16'h0020, 16'h0000}};
    exp_rd_q = '{16'h5A20};
    compare_issues("post_rst_iss");
    compare_reads("post_rst_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
